// File: rtl/timer_pkg.sv
// Shared constants for the BCD countdown timer: digit width, FSM encoding, mode indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'h0;

    // FSM encoding kept as plain constants so older tools and netlists see stable codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOADED = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_PAUSED = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Mode indices (bit position in the one-hot mode_sel)
    localparam int MODE_DELICATE = 0;
    localparam int MODE_NORMAL   = 1;
    localparam int MODE_POWER    = 2;
    localparam int MODE_DRYER    = 3;

    // Digit 1 is the seconds-tens digit and counts modulo tens_mod; all others are decimal
    function automatic int digit_mod(input int k, input int tens_mod);
        return (k == 1) ? tens_mod : 10;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load and borrow out to the next digit.
// Latency: value updates one cycle after load/dec_in; borrow_out is combinational.
// Backpressure: none; load has priority over dec_in every cycle.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec_in,
    output logic [DIGIT_W-1:0] value,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] value_q;
    logic [DIGIT_W-1:0] value_d;

    // Next digit value: load wins, otherwise count down and wrap 0 -> MOD-1
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec_in) begin
            if (value_q == BCD_ZERO) begin
                value_d = DIGIT_W'(MOD - 1);
            end else begin
                value_d = value_q - DIGIT_W'(1);
            end
        end
    end

    // Digit register, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign borrow_out = dec_in & (value_q == BCD_ZERO);

endmodule

// File: rtl/cycle_countdown_timer.sv
// MM:SS BCD countdown for the wash/dry cycle: per-mode preset load, start/pause/resume, done flag.
// Latency: all outputs registered, reflecting controls one cycle after they are sampled.
// Backpressure: none; controls are sampled every cycle with priority pause > start > load.
module cycle_countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_MODES  = 4,
    parameter int TENS_MOD   = 6,
    parameter logic [NUM_MODES*NUM_DIGITS*DIGIT_W-1:0] PRESETS =
        {16'h3000, 16'h2500, 16'h2000, 16'h1600}
) (
    input  logic                          CLK100MHZ,
    input  logic                          RST,
    input  logic                          tick_in,
    input  logic [NUM_MODES-1:0]          mode_sel,
    input  logic                          load,
    input  logic                          start,
    input  logic                          pause,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic                          running,
    output logic                          done,
    output logic                          load_err
);

    localparam int VAL_W = NUM_DIGITS * DIGIT_W;

    logic             tick_prev_q, tick_prev_d, tick_rise;
    logic [2:0]       state_q, state_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;
    logic             mode_ok;
    logic [VAL_W-1:0] preset_sel;
    logic [VAL_W-1:0] ld_val;
    logic             ld_en;
    logic             dec_en;
    logic             underflow;
    logic             cur_zero;
    logic             next_zero;

    // Rising-edge detect on the slow tick level
    always_comb begin
        tick_prev_d = tick_in;
        tick_rise   = tick_in & ~tick_prev_q;
    end

    // One-hot check on mode_sel and selection of the matching preset word
    always_comb begin
        int ones;
        ones       = 0;
        preset_sel = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode_sel[m]) begin
                ones       = ones + 1;
                preset_sel = PRESETS[m*VAL_W +: VAL_W];
            end
        end
        mode_ok = (ones == 1);
    end

    // 00..01 is the only value whose decrement lands on all-zero
    assign cur_zero  = (digits == '0);
    assign next_zero = (digits == VAL_W'(1));

    // Counting happens only in RUN on a tick edge, and a same-cycle pause suppresses it
    assign dec_en = (state_q == ST_RUN) & tick_rise & ~pause;

    // Control FSM: pause > start > load, with the tick decrement evaluated alongside
    always_comb begin
        state_d    = state_q;
        ld_en      = 1'b0;
        ld_val     = preset_sel;
        load_err_d = 1'b0;
        if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else begin
            if (start) begin
                case (state_q)
                    ST_LOADED: state_d = cur_zero ? ST_DONE : ST_RUN;
                    ST_PAUSED: state_d = ST_RUN;
                    default:   state_d = state_q;
                endcase
            end else if (load && (state_q != ST_RUN)) begin
                if (mode_ok) begin
                    state_d = ST_LOADED;
                    ld_en   = 1'b1;
                end else begin
                    load_err_d = 1'b1;
                end
            end
            // Underflow cannot occur from a nonzero RUN value; forcing zero keeps DONE at 00:00 regardless
            if (dec_en && (next_zero || underflow)) begin
                state_d = ST_DONE;
                ld_en   = 1'b1;
                ld_val  = '0;
            end
        end
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Control registers; tick_prev resets high so a tick already high is not seen as an edge
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            tick_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            tick_prev_q <= tick_prev_d;
            state_q     <= state_d;
            running_q   <= running_d;
            done_q      <= done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Digit chain: digit 0 takes the decrement, each higher digit takes the borrow from below
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic               dec_in;
        logic               borrow_out;
        logic [DIGIT_W-1:0] value;

        if (k == 0) begin : g_lsd
            assign dec_in = dec_en;
        end else begin : g_chain
            assign dec_in = g_digit[k-1].borrow_out;
        end

        bcd_down_digit #(
            .MOD(digit_mod(k, TENS_MOD))
        ) u_digit (
            .clk       (CLK100MHZ),
            .rst       (RST),
            .load      (ld_en),
            .load_val  (ld_val[k*DIGIT_W +: DIGIT_W]),
            .dec_in    (dec_in),
            .value     (value),
            .borrow_out(borrow_out)
        );

        assign digits[k*DIGIT_W +: DIGIT_W] = value;
    end

    assign underflow = g_digit[NUM_DIGITS-1].borrow_out;

    // Presets must be legal BCD for each digit's modulus
    for (genvar m = 0; m < NUM_MODES; m++) begin : g_chk_mode
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_chk_digit
            if (int'(PRESETS[(m*NUM_DIGITS+k)*DIGIT_W +: DIGIT_W]) >= digit_mod(k, TENS_MOD)) begin : g_bad
                $fatal(1, "PRESETS mode %0d digit %0d is not below its modulus", m, k);
            end
        end
    end

    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule
